alu_result_stage: RTL and testbench

Pipeline register stage directly downstream of the 32-bit ALU. It captures the ALU result, its flags and the destination register index into a 2-entry elastic buffer with a valid/ready handshake. It presents them to the writeback stage, so back-pressure from writeback never requires the ALU operands to be re-driven. It also keeps a saturating count of accepted overflow events for debug.

---
 rtl/alu_result_stage.sv | 146 ++++++++++++++
 tb/tb_alu_result_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Purpose: 2-entry elastic buffer (head + skid) between the ALU and writeback; it also counts accepted overflow beats.
// Latency: 1 cycle from input transfer to out_valid. out_* are driven straight from the head register.
// Backpressure: in_ready is registered and drops only when both entries are occupied; it does not depend on out_ready combinationally.
module alu_result_stage #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_result,
    input  logic             in_overflow,
    input  logic             in_zero,
    input  logic             in_equal,
    input  logic [4:0]       in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_result,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             out_equal,
    output logic [4:0]       out_rd,
    output logic [CNT_W-1:0] overflow_count
);

    typedef struct packed {
        logic [N-1:0] result;
        logic         overflow;
        logic         zero;
        logic         equal;
        logic [4:0]   rd;
    } beat_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_nxt;
    beat_t            head_q, skid_q, beat_in;
    logic             in_ready_q;
    logic             in_xfer, out_xfer;
    logic             head_ld_in, head_ld_skid, skid_ld, cnt_inc;
    logic [CNT_W-1:0] cnt_q;

    assign in_ready       = in_ready_q;
    assign out_valid      = (state_q != EMPTY);
    assign in_xfer        = in_valid & in_ready_q;
    assign out_xfer       = out_valid & out_ready;
    assign out_result     = head_q.result;
    assign out_overflow   = head_q.overflow;
    assign out_zero       = head_q.zero;
    assign out_equal      = head_q.equal;
    assign out_rd         = head_q.rd;
    assign overflow_count = cnt_q;

    // Form the beat to be stored. A write to x0 always reads back as zero, so the result is cleared and zero is set.
    always_comb begin
        beat_in.result   = in_result;
        beat_in.overflow = in_overflow;
        beat_in.zero     = in_zero;
        beat_in.equal    = in_equal;
        beat_in.rd       = in_rd;
        if (in_rd == 5'd0) begin
            beat_in.result = '0;
            beat_in.zero   = 1'b1;
        end
    end

    // Compute the next state and the load controls. Flush overrides every handshake.
    always_comb begin
        state_nxt    = state_q;
        head_ld_in   = 1'b0;
        head_ld_skid = 1'b0;
        skid_ld      = 1'b0;
        cnt_inc      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            cnt_inc = in_xfer & in_overflow;
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_nxt  = ONE;
                        head_ld_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && !out_xfer) begin
                        state_nxt = FULL;
                        skid_ld   = 1'b1;
                    end else if (!in_xfer && out_xfer) begin
                        state_nxt = EMPTY;
                    end else if (in_xfer && out_xfer) begin
                        head_ld_in = 1'b1;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_nxt    = ONE;
                        head_ld_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Update the state register. in_ready is registered from the next state, so it never depends on out_ready within the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_nxt;
            in_ready_q <= (state_nxt != FULL);
        end
    end

    // Update the data registers. The head takes either the incoming beat or the skid entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (head_ld_in)
                head_q <= beat_in;
            else if (head_ld_skid)
                head_q <= skid_q;
            if (skid_ld)
                skid_q <= beat_in;
        end
    end

    // Count accepted overflow beats. The count saturates at all-ones; a flush does not clear it.
    always_ff @(posedge clk) begin
        if (!rst)
            cnt_q <= '0;
        else if (cnt_inc && (cnt_q != {CNT_W{1'b1}}))
            cnt_q <= cnt_q + CNT_W'(1);
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Purpose: scoreboard bench for alu_result_stage, built with CNT_W=2 so that saturation is reachable.
// Latency: inputs change 1 time unit after each rising edge; the monitor samples on the falling edge.
// Backpressure: out_ready is driven per phase. Occupancy, in_ready and the counter come from a queue model.
module tb_alu_result_stage;

    localparam int N     = 32;
    localparam int CNT_W = 2;

    typedef struct packed {
        logic [N-1:0] result;
        logic         overflow;
        logic         zero;
        logic         equal;
        logic [4:0]   rd;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready;
    logic [N-1:0]     in_result;
    logic             in_overflow, in_zero, in_equal;
    logic [4:0]       in_rd;
    logic             out_valid, out_ready;
    logic [N-1:0]     out_result;
    logic             out_overflow, out_zero, out_equal;
    logic [4:0]       out_rd;
    logic [CNT_W-1:0] overflow_count;

    int               n_vec = 0;
    int               n_err = 0;
    bit               chk_en = 1'b0;
    exp_t             sb[$];
    int               exp_cnt = 0;

    alu_result_stage #(.N(N), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_result      (in_result),
        .in_overflow    (in_overflow),
        .in_zero        (in_zero),
        .in_equal       (in_equal),
        .in_rd          (in_rd),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_overflow   (out_overflow),
        .out_zero       (out_zero),
        .out_equal      (out_equal),
        .out_rd         (out_rd),
        .overflow_count (overflow_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [N-1:0] res, input logic ovf,
                         input logic z, input logic eq, input logic [4:0] rd);
        @(posedge clk);
        #1;
        in_valid    = v;
        in_result   = res;
        in_overflow = ovf;
        in_zero     = z;
        in_equal    = eq;
        in_rd       = rd;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    // Falling-edge monitor. It checks the state left by the last edge, then models the transfers that the next edge will perform.
    always @(negedge clk) begin
        exp_t e;
        bit   in_x, out_x;
        if (chk_en) begin
            check("out_valid", {63'd0, out_valid}, {63'd0, sb.size() != 0});
            check("in_ready", {63'd0, in_ready}, {63'd0, sb.size() < 2});
            check("ovf_count", {62'd0, overflow_count}, 64'(exp_cnt));
        end
        if (!rst) begin
            sb.delete();
            exp_cnt = 0;
        end else begin
            out_x = out_valid && out_ready;
            in_x  = in_valid && in_ready && !flush;
            if (flush) begin
                sb.delete();
            end else begin
                if (chk_en && out_x) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("out_result", {32'd0, out_result}, {32'd0, e.result});
                        check("out_overflow", {63'd0, out_overflow}, {63'd0, e.overflow});
                        check("out_zero", {63'd0, out_zero}, {63'd0, e.zero});
                        check("out_equal", {63'd0, out_equal}, {63'd0, e.equal});
                        check("out_rd", {59'd0, out_rd}, {59'd0, e.rd});
                    end
                end
                if (in_x) begin
                    e.result   = (in_rd == 5'd0) ? '0 : in_result;
                    e.zero     = (in_rd == 5'd0) ? 1'b1 : in_zero;
                    e.overflow = in_overflow;
                    e.equal    = in_equal;
                    e.rd       = in_rd;
                    sb.push_back(e);
                    if (in_overflow && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
                end
            end
        end
    end

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_result = '0;
        in_overflow = 1'b0; in_zero = 1'b0; in_equal = 1'b0; in_rd = 5'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", {32'd0, out_result}, 64'd0);
        check("rst_rd", {59'd0, out_rd}, 64'd0);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        chk_en = 1'b1;
        rst    = 1'b1;

        // Single beat with the consumer ready.
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 5'd5);
        idle(3);

        // Back-pressure: fill both entries, then release.
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 5'd1);
        drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 5'd2);
        idle(2);
        out_ready = 1'b1;
        idle(3);

        // Streaming 1..10 with the consumer always ready.
        for (int i = 1; i <= 10; i++)
            drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 5'(i));
        idle(2);

        // Write to x0: the result is cleared and zero is set; overflow and equal pass through.
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 5'd0);
        idle(2);

        // Flush while FULL with a beat offered.
        out_ready = 1'b0;
        drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 5'd3);
        drive(1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 5'd4);
        drive(1'b1, 32'h55, 1'b1, 1'b0, 1'b0, 5'd6);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        idle(1);

        // Flush while ONE: the offered beat is accepted by in_ready but discarded and not counted.
        drive(1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 5'd7);
        drive(1'b1, 32'h77, 1'b1, 1'b0, 1'b0, 5'd8);
        flush = 1'b1;
        drive(1'b1, 32'h88, 1'b0, 1'b1, 1'b0, 5'd9);
        flush = 1'b0;
        out_ready = 1'b1;
        idle(3);

        // Counter saturation starting from a fresh reset.
        idle(1);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        for (int i = 0; i < 5; i++)
            drive(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0, 1'b0, 5'd10);
        idle(1);

        // Reset in the middle of a transfer.
        out_ready = 1'b0;
        drive(1'b1, 32'hAA, 1'b1, 1'b0, 1'b0, 5'd11);
        out_ready = 1'b1;
        drive(1'b1, 32'hBB, 1'b1, 1'b0, 1'b0, 5'd12);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst2_result", {32'd0, out_result}, 64'd0);
        check("rst2_count", {62'd0, overflow_count}, 64'd0);
        rst      = 1'b1;
        in_valid = 1'b0;
        idle(2);

        // Drain whatever is left, within a bounded number of cycles.
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        check("drain", 64'(sb.size()), 64'd0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
